axi_lite_regfile: RTL and testbench

- Parametrised AXI4-Lite slave register bank.
- Provides NUM_REGS control/status registers, each AXI_DATA_WIDTH wide, to the accelerator datapath.
- Supports independent AW/W arrival, byte strobes, per-register read-only selection, SLVERR signalling and per-register write pulses.
- Sits between the host AXI-Lite interconnect and the core's configuration/status logic.

---
 rtl/axi_lite_regfile.sv | 253 +++++++++++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register bank: byte-strobed writes, read-only status registers, SLVERR, write pulses.
// Optional: define AXI_LITE_REGFILE_PROT_EN to reject non-secure (prot[1]=1) accesses with SLVERR.
module axi_lite_regfile #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = {NUM_REGS{1'b0}},
  parameter int STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic                                 axi_awvalid,
  output logic                                 axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]            axi_awaddr,
  input  logic [2:0]                           axi_awprot,
  input  logic                                 axi_wvalid,
  output logic                                 axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0]            axi_wdata,
  input  logic [STRB_WIDTH-1:0]                axi_wstrb,
  output logic                                 axi_bvalid,
  input  logic                                 axi_bready,
  output logic [1:0]                           axi_bresp,
  input  logic                                 axi_arvalid,
  output logic                                 axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]            axi_araddr,
  input  logic [2:0]                           axi_arprot,
  output logic                                 axi_rvalid,
  input  logic                                 axi_rready,
  output logic [AXI_DATA_WIDTH-1:0]            axi_rdata,
  output logic [1:0]                           axi_rresp,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0]   reg_out,
  input  logic [NUM_REGS*AXI_DATA_WIDTH-1:0]   reg_in,
  output logic [NUM_REGS-1:0]                  wr_pulse
);

  localparam int IDX_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W   = $clog2(NUM_REGS);
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = AXI_ADDR_WIDTH'(NUM_REGS * STRB_WIDTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  w_state_e                    w_state_q, w_state_d;
  logic                        awready_q, awready_d;
  logic                        wready_q, wready_d;
  logic                        bvalid_q, bvalid_d;
  logic [1:0]                  bresp_q, bresp_d;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]       wstrb_q, wstrb_d;
  logic [NUM_REGS-1:0]         wr_pulse_q, wr_pulse_d;
  logic [AXI_DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [AXI_DATA_WIDTH-1:0]   regs_d [NUM_REGS];
  logic [AXI_DATA_WIDTH-1:0]   reg_in_w [NUM_REGS];

  r_state_e                    r_state_q, r_state_d;
  logic                        arready_q, arready_d;
  logic                        rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                  rresp_q, rresp_d;

  logic                        aw_hs, w_hs, ar_hs, commit;
  logic [AXI_ADDR_WIDTH-1:0]   c_addr;
  logic [AXI_DATA_WIDTH-1:0]   c_data;
  logic [STRB_WIDTH-1:0]       c_strb;
  logic [IDX_W-1:0]            c_idx, r_idx;
  logic                        c_err, r_oor, w_prot_err, r_prot_err;

  assign aw_hs = axi_awvalid & awready_q;
  assign w_hs  = axi_wvalid & wready_q;
  assign ar_hs = axi_arvalid & arready_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_out[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs_q[i];
    assign reg_in_w[i] = reg_in[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  end

`ifdef AXI_LITE_REGFILE_PROT_EN
  logic [2:0] awprot_q, awprot_d;
  logic [2:0] c_prot;
  assign w_prot_err = c_prot[1];
  assign r_prot_err = axi_arprot[1];
`else
  logic unused_prot;
  assign unused_prot = ^{axi_awprot, axi_arprot};
  assign w_prot_err = 1'b0;
  assign r_prot_err = 1'b0;
`endif

  // Commit operands: whichever half arrived earlier comes from its holding register.
  always_comb begin
    c_addr = axi_awaddr;
    c_data = axi_wdata;
    c_strb = axi_wstrb;
`ifdef AXI_LITE_REGFILE_PROT_EN
    c_prot = axi_awprot;
    if (w_state_q == W_WAIT_DATA) c_prot = awprot_q;
`endif
    if (w_state_q == W_WAIT_DATA) c_addr = awaddr_q;
    if (w_state_q == W_WAIT_ADDR) begin
      c_data = wdata_q;
      c_strb = wstrb_q;
    end
  end

  assign c_idx = c_addr[IDX_LSB +: IDX_W];
  assign c_err = (c_addr >= ADDR_LIMIT) || RO_MASK[c_idx] || w_prot_err;

  always_comb begin
    w_state_d  = w_state_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    commit     = 1'b0;
`ifdef AXI_LITE_REGFILE_PROT_EN
    awprot_d   = awprot_q;
`endif
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
        end else if (aw_hs) begin
          awaddr_d  = axi_awaddr;
`ifdef AXI_LITE_REGFILE_PROT_EN
          awprot_d  = axi_awprot;
`endif
          w_state_d = W_WAIT_DATA;
        end else if (w_hs) begin
          wdata_d   = axi_wdata;
          wstrb_d   = axi_wstrb;
          w_state_d = W_WAIT_ADDR;
        end
      end
      W_WAIT_DATA: commit = w_hs;
      W_WAIT_ADDR: commit = aw_hs;
      W_RESP: begin
        if (axi_bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    if (commit) begin
      w_state_d = W_RESP;
      bvalid_d  = 1'b1;
      bresp_d   = c_err ? RESP_SLVERR : RESP_OKAY;
      if (!c_err) begin
        wr_pulse_d[c_idx] = 1'b1;
        for (int k = 0; k < STRB_WIDTH; k++) begin
          if (c_strb[k]) regs_d[c_idx][k*8 +: 8] = c_data[k*8 +: 8];
        end
      end
    end

    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_ADDR);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_DATA);
  end

  assign r_idx = axi_araddr[IDX_LSB +: IDX_W];
  assign r_oor = (axi_araddr >= ADDR_LIMIT);

  // Reads sample regs_q, so a same-edge write to the same register is not yet visible.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          if (r_oor || r_prot_err) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
          end else begin
            rdata_d = RO_MASK[r_idx] ? reg_in_w[r_idx] : regs_q[r_idx];
            rresp_d = RESP_OKAY;
          end
        end
      end
      R_RESP: begin
        if (axi_rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
`ifdef AXI_LITE_REGFILE_PROT_EN
      awprot_q   <= 3'b000;
`endif
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
`ifdef AXI_LITE_REGFILE_PROT_EN
      awprot_q   <= awprot_d;
`endif
    end
  end

  assign axi_awready = awready_q;
  assign axi_wready  = wready_q;
  assign axi_bvalid  = bvalid_q;
  assign axi_bresp   = bresp_q;
  assign axi_arready = arready_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign wr_pulse    = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Bench for axi_lite_regfile: transaction-level model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_axi_lite_regfile;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;
  localparam int SW = 4;

  logic            aclk = 1'b0;
  logic            areset;
  logic            axi_awvalid, axi_awready;
  logic [AW-1:0]   axi_awaddr;
  logic [2:0]      axi_awprot;
  logic            axi_wvalid, axi_wready;
  logic [DW-1:0]   axi_wdata;
  logic [SW-1:0]   axi_wstrb;
  logic            axi_bvalid, axi_bready;
  logic [1:0]      axi_bresp;
  logic            axi_arvalid, axi_arready;
  logic [AW-1:0]   axi_araddr;
  logic [2:0]      axi_arprot;
  logic            axi_rvalid, axi_rready;
  logic [DW-1:0]   axi_rdata;
  logic [1:0]      axi_rresp;
  logic [NR*DW-1:0] reg_out, reg_in;
  logic [NR-1:0]   wr_pulse;

  logic [NR-1:0]   ro_mask = 16'h0008;

  axi_lite_regfile #(
    .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(16'h0008)
  ) dut (
    .aclk(aclk), .areset(areset),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arprot(axi_arprot),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string what);
    checks++;
    errors++;
    $display("FAIL timeout_%s: got no handshake expected one within 100 cycles", what);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [NR];
  logic        m_aw_have, m_w_have;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_awprot;
  logic        e_awready, e_wready, e_arready, e_bvalid, e_rvalid;
  logic [1:0]  e_bresp, e_rresp;
  logic [31:0] e_rdata;
  logic [15:0] e_pulse;
  bit          mon_en = 0;

  function automatic logic [511:0] model_flat();
    logic [511:0] f;
    for (int i = 0; i < NR; i++) f[i*32 +: 32] = m_regs[i];
    return f;
  endfunction

  function automatic bit prot_bad(input logic [2:0] p);
`ifdef AXI_LITE_REGFILE_PROT_EN
    return p[1];
`else
    return 1'b0;
`endif
  endfunction

  always @(negedge aclk) begin
    logic       aw_hs, w_hs, ar_hs, err;
    logic [3:0] idx;
    if (mon_en) begin
      chk("awready", axi_awready, e_awready);
      chk("wready", axi_wready, e_wready);
      chk("arready", axi_arready, e_arready);
      chk("bvalid", axi_bvalid, e_bvalid);
      chk("rvalid", axi_rvalid, e_rvalid);
      chk("wr_pulse", wr_pulse, e_pulse);
      chk("reg_out", reg_out, model_flat());
      if (e_bvalid) chk("bresp", axi_bresp, e_bresp);
      if (e_rvalid) begin
        chk("rdata", axi_rdata, e_rdata);
        chk("rresp", axi_rresp, e_rresp);
      end
    end
    if (areset) begin
      mon_en = 1;
      for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
      m_aw_have = 0; m_w_have = 0;
      e_awready = 0; e_wready = 0; e_arready = 0;
      e_bvalid = 0; e_rvalid = 0; e_bresp = 0; e_rresp = 0; e_rdata = 0; e_pulse = 0;
    end else begin
      aw_hs = axi_awvalid && e_awready;
      w_hs  = axi_wvalid && e_wready;
      ar_hs = axi_arvalid && e_arready;
      // read sees register contents from before any write landing on the same edge
      if (e_rvalid && axi_rready) e_rvalid = 0;
      if (ar_hs) begin
        idx = axi_araddr[5:2];
        e_rvalid = 1;
        if (axi_araddr >= 32'd64 || prot_bad(axi_arprot)) begin
          e_rdata = 0; e_rresp = 2'b10;
        end else if (ro_mask[idx]) begin
          e_rdata = reg_in[idx*32 +: 32]; e_rresp = 2'b00;
        end else begin
          e_rdata = m_regs[idx]; e_rresp = 2'b00;
        end
      end
      if (e_bvalid && axi_bready) e_bvalid = 0;
      e_pulse = 0;
      if (aw_hs) begin m_aw_have = 1; m_awaddr = axi_awaddr; m_awprot = axi_awprot; end
      if (w_hs)  begin m_w_have = 1; m_wdata = axi_wdata; m_wstrb = axi_wstrb; end
      if (m_aw_have && m_w_have) begin
        idx = m_awaddr[5:2];
        err = (m_awaddr >= 32'd64) || ro_mask[idx] || prot_bad(m_awprot);
        e_bvalid = 1;
        e_bresp = err ? 2'b10 : 2'b00;
        if (!err) begin
          e_pulse = 16'(1) << idx;
          for (int k = 0; k < 4; k++)
            if (m_wstrb[k]) m_regs[idx][k*8 +: 8] = m_wdata[k*8 +: 8];
        end
        m_aw_have = 0; m_w_have = 0;
      end
      e_awready = !m_aw_have && !e_bvalid;
      e_wready  = !m_w_have && !e_bvalid;
      e_arready = !e_rvalid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge aclk); #1;
  endtask

  task automatic do_aw(input logic [31:0] a, input logic [2:0] p);
    bit ok = 0;
    axi_awaddr = a; axi_awprot = p; axi_awvalid = 1;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge aclk); if (axi_awready) ok = 1; end
    step(); axi_awvalid = 0;
    if (!ok) tmo("aw");
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    axi_wdata = d; axi_wstrb = s; axi_wvalid = 1;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge aclk); if (axi_wready) ok = 1; end
    step(); axi_wvalid = 0;
    if (!ok) tmo("w");
  endtask

  task automatic do_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    bit ok = 0;
    axi_awaddr = a; axi_awprot = p; axi_awvalid = 1;
    axi_wdata = d; axi_wstrb = s; axi_wvalid = 1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge aclk); if (axi_awready && axi_wready) ok = 1;
    end
    step(); axi_awvalid = 0; axi_wvalid = 0;
    if (!ok) tmo("aw_w");
  endtask

  task automatic wait_b(input int hold, output logic [1:0] resp);
    bit ok = 0;
    resp = 2'bxx;
    repeat (hold) step();
    axi_bready = 1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge aclk); if (axi_bvalid) begin ok = 1; resp = axi_bresp; end
    end
    step(); axi_bready = 0;
    if (!ok) tmo("b");
  endtask

  task automatic do_ar(input logic [31:0] a, input logic [2:0] p);
    bit ok = 0;
    axi_araddr = a; axi_arprot = p; axi_arvalid = 1;
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge aclk); if (axi_arready) ok = 1; end
    step(); axi_arvalid = 0;
    if (!ok) tmo("ar");
  endtask

  task automatic wait_r(input int hold, output logic [31:0] data, output logic [1:0] resp);
    bit ok = 0;
    data = 'x; resp = 2'bxx;
    repeat (hold) step();
    axi_rready = 1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge aclk); if (axi_rvalid) begin ok = 1; data = axi_rdata; resp = axi_rresp; end
    end
    step(); axi_rready = 0;
    if (!ok) tmo("r");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] p, output logic [1:0] resp);
    do_aw_w(a, d, s, p);
    wait_b(0, resp);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int hold,
                         output logic [31:0] data, output logic [1:0] resp);
    do_ar(a, p);
    wait_r(hold, data, resp);
  endtask

  // ---------------- directed sequence ----------------
  logic [1:0]  br, br2, rr, rr2;
  logic [31:0] rd, rd2;

  initial begin
    for (int i = 0; i < NR; i++) reg_in[i*32 +: 32] = 32'hB000_0000 | i;
    reg_in[3*32 +: 32] = 32'hA5A5_A5A5;
    areset = 1;
    axi_awvalid = 0; axi_awaddr = 0; axi_awprot = 0;
    axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 0; axi_bready = 0;
    axi_arvalid = 0; axi_araddr = 0; axi_arprot = 0; axi_rready = 0;
    repeat (3) step();
    @(negedge aclk);
    chk("rst_awready", axi_awready, 1'b0);
    chk("rst_arready", axi_arready, 1'b0);
    chk("rst_bresp", axi_bresp, 2'b00);
    chk("rst_rdata", axi_rdata, 32'h0);
    chk("rst_reg_out", reg_out, 512'h0);
    step(); areset = 0;
    @(negedge aclk);
    chk("rel_awready_low", axi_awready, 1'b0);
    @(negedge aclk);
    chk("rel_awready_high", axi_awready, 1'b1);
    step();

    // AW+W same cycle
    do_aw_w(32'h8, 32'hDEAD_BEEF, 4'hF, 3'b000);
    @(negedge aclk);
    chk("t1_pulse", wr_pulse, 16'h0004);
    chk("t1_bvalid", axi_bvalid, 1'b1);
    chk("t1_reg2", reg_out[2*32 +: 32], 32'hDEAD_BEEF);
    @(negedge aclk);
    chk("t1_pulse_gone", wr_pulse, 16'h0000);
    step();
    wait_b(0, br); chk("t1_bresp", br, 2'b00);
    do_read(32'h8, 3'b000, 0, rd, rr);
    chk("t1_rdata", rd, 32'hDEAD_BEEF); chk("t1_rresp", rr, 2'b00);

    // W two cycles ahead of AW, partial strobes
    do_write(32'h4, 32'hFFFF_FFFF, 4'hF, 3'b000, br);
    do_w(32'h1234_5678, 4'b0101);
    @(negedge aclk);
    chk("t2_wready_wait_addr", axi_wready, 1'b0);
    chk("t2_awready_wait_addr", axi_awready, 1'b1);
    step();
    do_aw(32'h4, 3'b000);
    @(negedge aclk);
    chk("t2_awready_resp", axi_awready, 1'b0);
    step();
    wait_b(2, br); chk("t2_bresp", br, 2'b00);
    do_read(32'h4, 3'b000, 0, rd, rr);
    chk("t2_rdata", rd, 32'hFF34_FF78);

    // read-only register
    do_aw_w(32'hC, 32'h1111_1111, 4'hF, 3'b000);
    @(negedge aclk);
    chk("t3_no_pulse", wr_pulse, 16'h0000);
    step();
    wait_b(0, br); chk("t3_bresp", br, 2'b10);
    do_read(32'hC, 3'b000, 0, rd, rr);
    chk("t3_rdata", rd, 32'hA5A5_A5A5); chk("t3_rresp", rr, 2'b00);

    // out of range and address boundaries
    do_write(32'h40, 32'h7777_7777, 4'hF, 3'b000, br); chk("t4_bresp", br, 2'b10);
    do_read(32'h40, 3'b000, 0, rd, rr);
    chk("t4_rdata", rd, 32'h0); chk("t4_rresp", rr, 2'b10);
    do_read(32'h0, 3'b000, 0, rd, rr); chk("t4_reg0_untouched", rd, 32'h0);
    do_write(32'h3C, 32'h0F0F_0F0F, 4'b1000, 3'b000, br); chk("t4_last_bresp", br, 2'b00);
    do_read(32'h3F, 3'b000, 0, rd, rr); chk("t4_last_rdata", rd, 32'h0F00_0000);
    do_read(32'h9, 3'b000, 0, rd, rr); chk("t4_lowbits", rd, 32'hDEAD_BEEF);

    // back-pressure with a read running during a pending write response
    do_aw_w(32'h10, 32'hCAFE_F00D, 4'hF, 3'b000);
    fork
      wait_b(5, br);
      do_read(32'h10, 3'b000, 5, rd, rr);
    join
    chk("t5_bresp", br, 2'b00); chk("t5_rdata", rd, 32'hCAFE_F00D);

    // same-edge read and write of one register
    fork
      do_write(32'h8, 32'h55AA_55AA, 4'hF, 3'b000, br2);
      do_read(32'h8, 3'b000, 0, rd2, rr2);
    join
    chk("t6_preval", rd2, 32'hDEAD_BEEF);
    do_read(32'h8, 3'b000, 0, rd, rr); chk("t6_postval", rd, 32'h55AA_55AA);

    // zero strobe: OKAY, pulse, no data change
    do_aw_w(32'h8, 32'hFFFF_FFFF, 4'h0, 3'b000);
    @(negedge aclk);
    chk("t7_pulse", wr_pulse, 16'h0004);
    step();
    wait_b(0, br); chk("t7_bresp", br, 2'b00);
    do_read(32'h8, 3'b000, 0, rd, rr); chk("t7_rdata", rd, 32'h55AA_55AA);

    // reset while waiting for write data
    do_aw(32'h14, 3'b000);
    @(negedge aclk);
    chk("t8_wait_data_aw", axi_awready, 1'b0);
    chk("t8_wait_data_w", axi_wready, 1'b1);
    step(); areset = 1;
    repeat (2) step(); areset = 0;
    @(negedge aclk);
    chk("t8_bvalid", axi_bvalid, 1'b0);
    chk("t8_regs", reg_out, 512'h0);
    step();
    do_write(32'h14, 32'h0BAD_CAFE, 4'hF, 3'b000, br); chk("t8_bresp", br, 2'b00);
    do_read(32'h14, 3'b000, 0, rd, rr); chk("t8_rdata", rd, 32'h0BAD_CAFE);
    do_read(32'h8, 3'b000, 0, rd, rr); chk("t8_reg2_cleared", rd, 32'h0);

`ifdef AXI_LITE_REGFILE_PROT_EN
    do_write(32'h18, 32'h1357_9BDF, 4'hF, 3'b010, br); chk("t9_prot_bresp", br, 2'b10);
    do_read(32'h18, 3'b000, 0, rd, rr); chk("t9_prot_noupdate", rd, 32'h0);
    do_write(32'h18, 32'h1357_9BDF, 4'hF, 3'b001, br); chk("t9_secure_bresp", br, 2'b00);
    do_read(32'h18, 3'b010, 0, rd, rr);
    chk("t9_prot_rdata", rd, 32'h0); chk("t9_prot_rresp", rr, 2'b10);
`endif

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

endmodule
